// File: rtl/vending_machine_multi_if.sv
// vending_machine_multi_if: select, coin, cancel and dispense signals of the vending controller
interface vending_machine_multi_if #(parameter int SEL_W = 2, parameter int CRED_W = 5);
  logic [SEL_W-1:0] choice, prd;
  logic sel_vld, cancel, prd_vld, chng_vld, coin_rej, sold_out, busy;
  logic [1:0] in_mny, chng;
  logic [CRED_W-1:0] credit;
  modport master(output choice, sel_vld, in_mny, cancel,
                 input prd, prd_vld, chng, chng_vld, coin_rej, sold_out, busy, credit);
  modport slave(input choice, sel_vld, in_mny, cancel,
                output prd, prd_vld, chng, chng_vld, coin_rej, sold_out, busy, credit);
endinterface

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-product vending controller with stock, cancel/refund
// and serial change output; all money is kept in Rs5 units.
module vending_machine_multi #(
  parameter int NUM_PRD = 4,
  parameter int PRICE_W = 4,
  parameter logic [NUM_PRD*PRICE_W-1:0] PRICES = {4'd4, 4'd3, 4'd2, 4'd1},
  parameter int STOCK_W = 3,
  parameter int STOCK_INIT = 3,
  parameter int CRED_W = 5,
  parameter int MAX_CREDIT = 15
) (
  input logic clk,
  input logic rst,
  vending_machine_multi_if.slave bus
);
  localparam int SEL_W = NUM_PRD > 1 ? $clog2(NUM_PRD) : 1;
  localparam logic [CRED_W:0] MAX_C = (CRED_W+1)'(MAX_CREDIT);
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;
  state_t state, state_n;
  logic [CRED_W-1:0] credit, credit_n, rem, rem_n, coin_val;
  logic [SEL_W-1:0] sel, sel_n;
  logic [STOCK_W-1:0] stock [NUM_PRD];
  logic [CRED_W:0] val, sum;
  logic [PRICE_W-1:0] price;
  logic [1:0] coin;
  logic rej_n, sold_n, rej_q, sold_q, choice_ok;
  assign price = PRICES[sel*PRICE_W +: PRICE_W];
  assign val = (bus.in_mny == 2'd3) ? (CRED_W+1)'(4) : (CRED_W+1)'(bus.in_mny);
  assign sum = {1'b0, credit} + val;
  assign choice_ok = int'(bus.choice) < NUM_PRD;
  // Greedy change: always pay out the largest coin that still fits.
  assign coin = (rem >= CRED_W'(4)) ? 2'd3 : (rem >= CRED_W'(2)) ? 2'd2 : 2'd1;
  assign coin_val = (coin == 2'd3) ? CRED_W'(4) : CRED_W'(coin);
  always_comb begin
    state_n = state;
    credit_n = credit;
    rem_n = rem;
    sel_n = sel;
    rej_n = 1'b0;
    sold_n = 1'b0;
    case (state)
      IDLE: begin
        rej_n = bus.in_mny != 2'd0;
        if (bus.sel_vld && choice_ok) begin
          if (stock[bus.choice] != '0) begin
            sel_n = bus.choice;
            state_n = COLLECT;
          end else sold_n = 1'b1;
        end
      end
      COLLECT: begin
        if (bus.cancel) begin
          rej_n = bus.in_mny != 2'd0;
          rem_n = credit;
          credit_n = '0;
          state_n = (credit != '0) ? CHANGE : IDLE;
        end else if (bus.in_mny != 2'd0) begin
          if (sum <= MAX_C) begin
            credit_n = sum[CRED_W-1:0];
            if (sum >= (CRED_W+1)'(price)) state_n = VEND;
          end else rej_n = 1'b1;
        end
      end
      VEND: begin
        rem_n = credit - CRED_W'(price);
        credit_n = '0;
        state_n = (rem_n != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_n = bus.in_mny != 2'd0;
        rem_n = rem - coin_val;
        if (rem_n == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      credit <= '0;
      rem <= '0;
      sel <= '0;
      rej_q <= 1'b0;
      sold_q <= 1'b0;
      for (int i = 0; i < NUM_PRD; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state <= state_n;
      credit <= credit_n;
      rem <= rem_n;
      sel <= sel_n;
      rej_q <= rej_n;
      sold_q <= sold_n;
      if (state == VEND && stock[sel] != '0) stock[sel] <= stock[sel] - 1'b1;
    end
  end
  assign bus.prd_vld = state == VEND;
  assign bus.prd = (state == VEND) ? sel : '0;
  assign bus.chng_vld = state == CHANGE;
  assign bus.chng = (state == CHANGE) ? coin : 2'd0;
  assign bus.coin_rej = rej_q;
  assign bus.sold_out = sold_q;
  assign bus.busy = state != IDLE;
  assign bus.credit = credit;
endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parametrised successor to the single-shot vending controller. It supports NUM_PRD products with per-product prices and stock counters, and accepts Rs5, Rs10 and Rs20 coins. It adds a cancel/refund path and dispenses change serially, one coin per cycle, on a valid-qualified output. All money is held internally in Rs5 units.

Parameters:
NUM_PRD, 4, number of products; SEL_W = clog2(NUM_PRD)
PRICE_W, 4, width of each price field, in Rs5 units
PRICES, {4'd4,4'd3,4'd2,4'd1}, packed NUM_PRD*PRICE_W prices; product i uses bits [i*PRICE_W +: PRICE_W]; defaults are p0=Rs5, p1=Rs10, p2=Rs15, p3=Rs20
STOCK_W, 3, width of each stock counter
STOCK_INIT, 3, stock loaded into every product counter on reset
CRED_W, 5, width of the credit register
MAX_CREDIT, 15, maximum credit in units; any coin that would exceed it is rejected

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
choice  in  SEL_W  product select, sampled when sel_vld=1
sel_vld  in  1  select strobe
in_mny  in  2  coin this cycle: 0 none, 1 Rs5, 2 Rs10, 3 Rs20
cancel  in  1  abort the purchase and refund credit
prd  out  SEL_W  id of the dispensed product, valid while prd_vld=1
prd_vld  out  1  product dispensed (one-cycle pulse)
chng  out  2  change coin: 1 Rs5, 2 Rs10, 3 Rs20; 0 when chng_vld=0
chng_vld  out  1  change coin valid this cycle
coin_rej  out  1  coin returned this cycle (pulse)
sold_out  out  1  selected product has zero stock (pulse)
busy  out  1  high in every state except IDLE
credit  out  CRED_W  current credit in units

Behaviour:
- States: IDLE, COLLECT, VEND, CHANGE. All outputs are decoded from registers only.
- Reset (async):
  - State goes to IDLE.
  - credit=0, sel=0, remaining-change=0.
  - Every stock counter loads STOCK_INIT.
  - All outputs go to 0.
  - Reset mid-purchase discards credit with no refund coins.
- Coin values in units: code 1 = 1, code 2 = 2, code 3 = 4.
- IDLE:
  - sel_vld with choice<NUM_PRD and stock[choice]>0: latch sel=choice, go to COLLECT.
  - sel_vld with stock[choice]==0: sold_out=1 for the next cycle, stay in IDLE.
  - sel_vld with choice>=NUM_PRD: ignored.
  - Any nonzero in_mny: coin_rej=1 next cycle, credit unchanged.
- COLLECT:
  - Coin accepted when credit+value <= MAX_CREDIT; credit updates at that edge.
  - Otherwise the coin is rejected: coin_rej pulse, credit unchanged.
  - If accepted credit_next >= PRICES[sel], go to VEND at the same edge. prd_vld is therefore high in the cycle after the satisfying coin (latency 1).
  - cancel=1: remaining=credit, credit=0, go to CHANGE, or to IDLE if credit is 0. No product is dispensed.
  - cancel together with a coin: cancel wins, the coin is rejected (coin_rej).
  - sel_vld is ignored.
- VEND (exactly one cycle):
  - prd_vld=1, prd=sel.
  - At exit: stock[sel] decrements; remaining=credit-PRICES[sel]; credit=0.
  - Next state is CHANGE if remaining>0, else IDLE.
- CHANGE:
  - Each cycle chng_vld=1 and chng is the largest coin <= remaining (>=4 gives 3, >=2 gives 2, else 1).
  - remaining decrements by that coin's value at the edge.
  - When remaining reaches 0, go to IDLE.
  - Coins are rejected with coin_rej; sel_vld and cancel are ignored.
- Stock counters never underflow; a product reaching 0 stock is blocked at selection.
- Simultaneous sel_vld and coin in IDLE: the selection is taken and the coin is rejected.

Test Plan:
- Select choice=3 (Rs20) -> coins 2,1,2 on consecutive cycles -> credit goes 2,3, then prd_vld=1 with prd=3 in the cycle after the third coin -> one change cycle with chng=1 (Rs5) -> IDLE, busy=0.
- Select choice=0 (Rs5) -> coin 3 (Rs20) -> VEND next cycle -> change chng=2 then chng=1 on consecutive cycles (3 units) -> IDLE.
- Select choice=2 (Rs15) -> coins 2,1 -> VEND, no change cycles -> repeat the purchase three times; the fourth select gives a sold_out pulse and stays in IDLE; STOCK_INIT=3.
- Select choice=3 -> coins 2,1 -> cancel asserted together with coin 2 -> coin_rej=1, no prd_vld -> change chng=2 then chng=1 -> IDLE.
- Coin 1 in IDLE -> coin_rej=1, credit stays 0. With MAX_CREDIT=5 and a price of 8, coins 3 then 2 -> second coin rejected, credit stays 4.
- rst asserted asynchronously mid-CHANGE (1 unit left) -> chng_vld drops immediately, state IDLE, credit=0, all stock counters back to 3.
